// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int NUM_PORTS   = 2;
    localparam int PORT_ICACHE = 0;
    localparam int PORT_DCACHE = 1;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the arbiter; master = arbiter side,
// slave = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0_en;
    logic          req0_rw;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic [DW-1:0] req0_rdata;
    logic          req0_finish;

    logic          req1_en;
    logic          req1_rw;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic [DW-1:0] req1_rdata;
    logic          req1_finish;

    logic          mem_en;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_op_finish;

    logic [1:0]    grant;
    logic          timeout_err;

    modport master (
        input  req0_en, req0_rw, req0_addr, req0_wdata,
        output req0_rdata, req0_finish,
        input  req1_en, req1_rw, req1_addr, req1_wdata,
        output req1_rdata, req1_finish,
        output mem_en, mem_rw, mem_addr, mem_wdata,
        input  mem_rdata, mem_op_finish,
        output grant, timeout_err
    );

    modport slave (
        output req0_en, req0_rw, req0_addr, req0_wdata,
        input  req0_rdata, req0_finish,
        output req1_en, req1_rw, req1_addr, req1_wdata,
        input  req1_rdata, req1_finish,
        input  mem_en, mem_rw, mem_addr, mem_wdata,
        output mem_rdata, mem_op_finish,
        input  grant, timeout_err
    );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select for the arbiter. ARB_ROUND_ROBIN_EN: ties go to the
// port not granted last; otherwise ties go to the data cache (port 1).
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic                 last_i,
`endif
    output logic                 valid_o,
    output logic                 sel_o
);

    always_comb begin
        valid_o = |req_i;
        sel_o   = 1'b0;
        if (req_i[PORT_DCACHE] && !req_i[PORT_ICACHE]) begin
            sel_o = 1'b1;
        end else if (&req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            sel_o = ~last_i;
`else
            sel_o = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: IDLE/BUSY/RELEASE FSM, registered memory request,
// per-port held read data and busy watchdog. Build option macro: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    localparam int            CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_e                   state_q, state_d;
    logic                         mem_en_q, mem_en_d;
    logic                         mem_rw_q, mem_rw_d;
    logic [AW-1:0]                mem_addr_q, mem_addr_d;
    logic [DW-1:0]                mem_wdata_q, mem_wdata_d;
    logic [NUM_PORTS-1:0]         grant_q, grant_d;
    logic [NUM_PORTS-1:0]         fin_q, fin_d;
    logic [NUM_PORTS-1:0][DW-1:0] rdata_q, rdata_d;
    logic                         err_q, err_d;
    logic [CW-1:0]                cnt_q, cnt_d;

    logic [NUM_PORTS-1:0] req_vec;
    logic                 pick_vld;
    logic                 pick_sel;
    logic                 owner;
    logic                 tmo_hit;

    assign req_vec = {bus.req1_en, bus.req0_en};
    assign owner   = grant_q[PORT_DCACHE];
    // Counter sits at TIMEOUT_CYCLES-1 on the edge that completes the last busy cycle.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    arb_pick u_pick (
        .req_i   (req_vec),
        .last_i  (last_q),
        .valid_o (pick_vld),
        .sel_o   (pick_sel)
    );
`else
    arb_pick u_pick (
        .req_i   (req_vec),
        .valid_o (pick_vld),
        .sel_o   (pick_sel)
    );
`endif

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_d     = grant_q;
        fin_d       = '0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    mem_en_d    = 1'b1;
                    mem_rw_d    = pick_sel ? bus.req1_rw    : bus.req0_rw;
                    mem_addr_d  = pick_sel ? bus.req1_addr  : bus.req0_addr;
                    mem_wdata_d = pick_sel ? bus.req1_wdata : bus.req0_wdata;
                    grant_d     = port_onehot(pick_sel);
                    cnt_d       = '0;
                    state_d     = BUSY;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d      = pick_sel;
`endif
                end
            end
            BUSY: begin
                // A real completion on the watchdog edge wins over the abort.
                if (bus.mem_op_finish || tmo_hit) begin
                    mem_en_d       = 1'b0;
                    grant_d        = '0;
                    fin_d[owner]   = 1'b1;
                    rdata_d[owner] = bus.mem_op_finish ? bus.mem_rdata : '0;
                    if (!bus.mem_op_finish) err_d = 1'b1;
                    state_d        = RELEASE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= RW_READ;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            grant_q     <= '0;
            fin_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            grant_q     <= grant_d;
            fin_q       <= fin_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= 1'b0;
        else     last_q <= last_d;
    end
`endif

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_rw      = mem_rw_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.grant       = grant_q;
    assign bus.timeout_err = err_q;
    assign bus.req0_finish = fin_q[PORT_ICACHE];
    assign bus.req1_finish = fin_q[PORT_DCACHE];
    assign bus.req0_rdata  = rdata_q[PORT_ICACHE];
    assign bus.req1_rdata  = rdata_q[PORT_DCACHE];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter; a request-level model (pending set plus
// last winner) predicts each grant, latched request, completion timing and read data.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]    grant, gfin;
        logic [AW-1:0] addr;
        logic          rw;
        logic [DW-1:0] wdata, rd0, rd1;
        logic          en_fin, err_fin;
        int            fin_idx, f0, f1, wait_n;
        bit            stable, no_en;
    } txn_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: outstanding request per port and the last port served.
    bit            m_pend [2];
    logic          m_rw   [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wd   [2];
    int            m_last;

    function automatic int pick_model();
        if (m_pend[0] && m_pend[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (m_last == 1) ? 0 : 1;
`else
            return 1;
`endif
        end
        return m_pend[1] ? 1 : 0;
    endfunction

    function automatic logic [1:0] port_bit(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic int fcnt(input txn_t t, input int p);
        return (p == 1) ? t.f1 : t.f0;
    endfunction

    function automatic logic [DW-1:0] rdat(input txn_t t, input int p);
        return (p == 1) ? t.rd1 : t.rd0;
    endfunction

    task automatic set_en(input int p, input logic v);
        if (p == 1) bus.req1_en = v; else bus.req0_en = v;
    endtask

    task automatic post(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 1) begin
            bus.req1_rw = rw; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_en = 1'b1;
        end else begin
            bus.req0_rw = rw; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_en = 1'b1;
        end
        m_pend[p] = 1'b1; m_rw[p] = rw; m_addr[p] = a; m_wd[p] = d;
    endtask

    task automatic retire(input int p, input bit keep);
        m_pend[p] = keep;
        m_last    = p;
    endtask

    // Memory + requester behaviour for one transfer. idx 0 is the first negedge with
    // mem_en high; finish is driven so the arbiter samples it lat edges later
    // (lat 0: never). Returns at the negedge right before IDLE samples again.
    task automatic serve(input int lat, input logic [DW-1:0] rd, input bit keep,
                         input bit chg, input logic [AW-1:0] new_addr, output txn_t t);
        int w;
        t.fin_idx = -1; t.f0 = 0; t.f1 = 0; t.wait_n = 0; t.stable = 1'b1; t.no_en = 1'b0;
        t.gfin = 2'bxx; t.en_fin = 1'bx; t.err_fin = 1'bx; t.rd0 = '0; t.rd1 = '0;
        t.grant = '0; t.addr = '0; t.rw = 1'b0; t.wdata = '0;
        while (!bus.mem_en && t.wait_n < 20) begin
            @(negedge clk);
            t.wait_n++;
        end
        if (!bus.mem_en) begin
            t.no_en = 1'b1;
            return;
        end
        t.grant = bus.grant; t.addr = bus.mem_addr; t.rw = bus.mem_rw; t.wdata = bus.mem_wdata;
        w = bus.grant[1] ? 1 : 0;
        for (int idx = 0; idx < 40; idx++) begin
            if (bus.req0_finish) t.f0++;
            if (bus.req1_finish) t.f1++;
            if (t.fin_idx >= 0 && idx == t.fin_idx + 1) break;
            if (t.fin_idx < 0 && (bus.req0_finish || bus.req1_finish)) begin
                t.fin_idx = idx; t.gfin = bus.grant; t.en_fin = bus.mem_en;
                t.rd0 = bus.req0_rdata; t.rd1 = bus.req1_rdata; t.err_fin = bus.timeout_err;
                if (!keep) set_en(w, 1'b0);
            end
            if (t.fin_idx < 0 && {bus.mem_addr, bus.mem_rw, bus.mem_wdata} !== {t.addr, t.rw, t.wdata})
                t.stable = 1'b0;
            if (chg && idx == 1) begin
                if (w == 1) bus.req1_addr = new_addr; else bus.req0_addr = new_addr;
            end
            bus.mem_op_finish = (lat != 0 && idx == lat - 1);
            bus.mem_rdata     = (lat != 0 && idx == lat - 1) ? rd : DW'($urandom);
            @(negedge clk);
        end
        bus.mem_op_finish = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.mem_en, bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.grant, bus.req0_finish,
             bus.req1_finish, bus.req0_rdata, bus.req1_rdata, bus.timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b rw=%b addr=%h wd=%h grant=%b fin=%b%b rd0=%h rd1=%h err=%b want all zero",
                     bus.mem_en, bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.grant, bus.req1_finish,
                     bus.req0_finish, bus.req0_rdata, bus.req1_rdata, bus.timeout_err);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.mem_en !== 1'b0 || bus.grant !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_no_request: got en=%b grant=%b want 0 00", bus.mem_en, bus.grant);
        end
    endtask

    task automatic test_single_read();
        txn_t t;
        post(0, RW_READ, 32'h40, 32'h0);
        serve(3, 32'h1234, 1'b0, 1'b0, '0, t);
        n_tests++;
        if (t.grant !== 2'b01 || t.addr !== 32'h40 || t.rw !== 1'b0) begin
            n_fail++;
            $display("FAIL read_request: got grant=%b addr=%h rw=%b want 01 00000040 0", t.grant, t.addr, t.rw);
        end
        n_tests++;
        if (t.fin_idx != 3 || t.f0 != 1 || t.f1 != 0) begin
            n_fail++;
            $display("FAIL read_finish: got idx=%0d f0=%0d f1=%0d want 3 1 0", t.fin_idx, t.f0, t.f1);
        end
        n_tests++;
        if (t.rd0 !== 32'h1234 || t.gfin !== 2'b00 || t.en_fin !== 1'b0) begin
            n_fail++;
            $display("FAIL read_data: got rd0=%h grant=%b en=%b want 00001234 00 0", t.rd0, t.gfin, t.en_fin);
        end
        retire(0, 1'b0);
    endtask

    task automatic test_addr_hold();
        txn_t t;
        post(0, RW_READ, 32'h40, 32'h0);
        serve(5, 32'hBEEF, 1'b0, 1'b1, 32'h200, t);
        n_tests++;
        if (!t.stable || t.addr !== 32'h40 || t.rd0 !== 32'hBEEF) begin
            n_fail++;
            $display("FAIL addr_hold: got stable=%0d addr=%h rd0=%h want 1 00000040 0000beef", t.stable, t.addr, t.rd0);
        end
        retire(0, 1'b0);
    endtask

    task automatic test_collision();
        txn_t t;
        int e;
        logic [DW-1:0] rd;
        // Round 1 follows a port-0 grant, round 2 follows a lone port-1 grant.
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                post(1, RW_READ, 32'h3C0, 32'h0);
                serve(2, 32'h5151, 1'b0, 1'b0, '0, t);
                retire(1, 1'b0);
            end
            post(1, RW_WRITE, 32'h100, 32'd100);
            post(0, RW_READ, 32'h40, 32'h0);
            for (int k = 0; k < 2; k++) begin
                e  = pick_model();
                rd = $urandom;
                serve(1 + k, rd, 1'b0, 1'b0, '0, t);
                n_tests++;
                if (t.grant !== port_bit(e) || t.addr !== m_addr[e] || t.rw !== m_rw[e] || t.wdata !== m_wd[e]) begin
                    n_fail++;
                    $display("FAIL collision_req r%0d k%0d: got grant=%b addr=%h rw=%b wd=%h want %b %h %b %h",
                             r, k, t.grant, t.addr, t.rw, t.wdata, port_bit(e), m_addr[e], m_rw[e], m_wd[e]);
                end
                n_tests++;
                if (rdat(t, e) !== rd || fcnt(t, e) != 1 || fcnt(t, 1 - e) != 0 || t.fin_idx != 1 + k) begin
                    n_fail++;
                    $display("FAIL collision_done r%0d k%0d: got rd=%h fw=%0d fl=%0d idx=%0d want %h 1 0 %0d",
                             r, k, rdat(t, e), fcnt(t, e), fcnt(t, 1 - e), t.fin_idx, rd, 1 + k);
                end
                retire(e, 1'b0);
            end
        end
    endtask

    task automatic test_back_to_back();
        txn_t t;
        int e;
        post(0, RW_READ, 32'h44, 32'h0);
        serve(1, 32'h1, 1'b0, 1'b0, '0, t);
        retire(0, 1'b0);
        post(1, RW_WRITE, 32'h180, 32'hA5A5);
        post(0, RW_READ, 32'h80, 32'h0);
        // First winner keeps its enable up through its completion.
        for (int k = 0; k < 3; k++) begin
            e = pick_model();
            serve(2, 32'h7700 + k, (k == 0), 1'b0, '0, t);
            n_tests++;
            if (t.grant !== port_bit(e) || t.addr !== m_addr[e] || fcnt(t, e) != 1 || fcnt(t, 1 - e) != 0) begin
                n_fail++;
                $display("FAIL back_to_back k%0d: got grant=%b addr=%h fw=%0d fl=%0d want %b %h 1 0",
                         k, t.grant, t.addr, fcnt(t, e), fcnt(t, 1 - e), port_bit(e), m_addr[e]);
            end
            retire(e, (k == 0));
        end
    endtask

    task automatic test_random();
        txn_t t;
        int e, lat;
        logic [DW-1:0] rd;
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < 2; p++)
                if (!m_pend[p] && $urandom_range(0, 1) == 1)
                    post(p, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            if (!m_pend[0] && !m_pend[1])
                post($urandom_range(0, 1), 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            e   = pick_model();
            lat = $urandom_range(1, TMO);
            rd  = $urandom;
            serve(lat, rd, 1'b0, 1'b1, AW'($urandom), t);
            n_tests++;
            if (t.no_en || t.grant !== port_bit(e) || t.addr !== m_addr[e] || t.rw !== m_rw[e] || t.wdata !== m_wd[e] || !t.stable) begin
                n_fail++;
                $display("FAIL random_req i%0d: got grant=%b addr=%h rw=%b wd=%h stable=%0d want %b %h %b %h 1",
                         i, t.grant, t.addr, t.rw, t.wdata, t.stable, port_bit(e), m_addr[e], m_rw[e], m_wd[e]);
            end
            n_tests++;
            if (t.fin_idx != lat || fcnt(t, e) != 1 || fcnt(t, 1 - e) != 0 || rdat(t, e) !== rd || t.gfin !== 2'b00) begin
                n_fail++;
                $display("FAIL random_done i%0d: got idx=%0d fw=%0d fl=%0d rd=%h grant=%b want %0d 1 0 %h 00",
                         i, t.fin_idx, fcnt(t, e), fcnt(t, 1 - e), rdat(t, e), t.gfin, lat, rd);
            end
            retire(e, 1'b0);
        end
    endtask

    task automatic test_timeout_boundary();
        txn_t t;
        post(1, RW_READ, 32'h500, 32'h0);
        serve(TMO, 32'hCAFE, 1'b0, 1'b0, '0, t);
        n_tests++;
        if (t.fin_idx != TMO || t.rd1 !== 32'hCAFE || t.err_fin !== 1'b0 || t.f1 != 1) begin
            n_fail++;
            $display("FAIL timeout_boundary: got idx=%0d rd1=%h err=%b f1=%0d want %0d 0000cafe 0 1",
                     t.fin_idx, t.rd1, t.err_fin, t.f1, TMO);
        end
        retire(1, 1'b0);
    endtask

    task automatic test_timeout();
        txn_t t;
        post(1, RW_READ, 32'h504, 32'h0);
        serve(0, '0, 1'b0, 1'b0, '0, t);
        n_tests++;
        if (t.fin_idx != TMO || t.f1 != 1 || t.f0 != 0 || t.rd1 !== '0 || t.err_fin !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_abort: got idx=%0d f1=%0d f0=%0d rd1=%h err=%b want %0d 1 0 0 1",
                     t.fin_idx, t.f1, t.f0, t.rd1, t.err_fin, TMO);
        end
        retire(1, 1'b0);
        post(0, RW_WRITE, 32'h508, 32'h99);
        serve(3, 32'h4242, 1'b0, 1'b0, '0, t);
        n_tests++;
        if (t.grant !== 2'b01 || t.fin_idx != 3 || t.rd0 !== 32'h4242 || bus.timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_after: got grant=%b idx=%0d rd0=%h err=%b want 01 3 00004242 1",
                     t.grant, t.fin_idx, t.rd0, bus.timeout_err);
        end
        retire(0, 1'b0);
    endtask

    task automatic test_reset_mid_busy();
        txn_t t;
        int n;
        int fins;
        post(0, RW_READ, 32'h40, 32'h0);
        n = 0;
        while (!bus.mem_en && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.mem_en, bus.mem_addr, bus.grant, bus.req0_finish, bus.req1_finish,
             bus.req0_rdata, bus.req1_rdata, bus.timeout_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got en=%b addr=%h grant=%b rd0=%h err=%b want all zero",
                     bus.mem_en, bus.mem_addr, bus.grant, bus.req0_rdata, bus.timeout_err);
        end
        fins = 0;
        repeat (2) begin
            @(negedge clk);
            fins += int'(bus.req0_finish) + int'(bus.req1_finish);
        end
        n_tests++;
        if (fins != 0) begin
            n_fail++;
            $display("FAIL reset_no_finish: got %0d pulses want 0", fins);
        end
        rst    = 1'b0;
        m_last = 0;
        serve(2, 32'h6060, 1'b0, 1'b0, '0, t);
        n_tests++;
        if (t.wait_n != 1 || t.grant !== 2'b01 || t.addr !== 32'h40 || t.fin_idx != 2 || t.rd0 !== 32'h6060) begin
            n_fail++;
            $display("FAIL reset_regrant: got wait=%0d grant=%b addr=%h idx=%0d rd0=%h want 1 01 00000040 2 00006060",
                     t.wait_n, t.grant, t.addr, t.fin_idx, t.rd0);
        end
        retire(0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_en = 1'b0; bus.req0_rw = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_en = 1'b0; bus.req1_rw = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
        bus.mem_rdata = '0; bus.mem_op_finish = 1'b0;
        m_pend[0] = 1'b0; m_pend[1] = 1'b0; m_last = 0;
        test_reset();
        test_single_read();
        test_addr_hold();
        test_collision();
        test_back_to_back();
        test_random();
        test_timeout_boundary();
        test_timeout();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within 500000 ns");
        $fatal(1, "bench stalled");
    end

endmodule
